scalar_add_ctrl: RTL
====================

Name: scalar_add_ctrl

Overview:
Host-facing control/compute block for the Verilator scalar-add flow. It replaces direct backdoor pokes of DUT registers with a proper register-mapped interface: the test harness writes operands and a start bit, a small FSM performs the add over a configurable number of cycles, and the harness polls status/result. It sits directly downstream of the host driver and is the compute stage the driver exercises.

Parameters:
WIDTH, 32, operand/result width in bits
LAT, 2, cycles spent in ADD state (≥1); models multi-cycle datapath
ID_VALUE, 32'h5CA1_0ADD, constant returned at ID register

Ports:
clock  input  1  single clock, all logic rising-edge
reset  input  1  synchronous, active-high
host_wr  input  1  write strobe, one cycle per write
host_rd  input  1  read strobe, one cycle per read
host_addr  input  3  register index
host_wdata  input  WIDTH  write data
host_rdata  output  WIDTH  read data, valid when host_rvalid
host_rvalid  output  1  pulses 1 cycle after host_rd
irq  output  1  level: STATUS.done & CTRL.irq_en

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; A,B,Y,CYCLES=0; CTRL=0; STATUS=0; host_rdata=0; host_rvalid=0; irq=0. Reset mid-ADD aborts: no result written, done not set.
- Register map: 0 CTRL (bit0 start, write-1 self-clearing, reads 0; bit1 irq_en R/W); 1 STATUS (bit0 busy RO, bit1 done sticky W1C, bit2 carry RO); 2 A R/W; 3 B R/W; 4 Y RO; 5 CYCLES RO; 6 ID RO = ID_VALUE; 7 reserved, reads 0, writes ignored.
- Read: host_rd at cycle N -> host_rdata/host_rvalid at N+1; host_rvalid low otherwise; host_rdata holds last value when not valid.
- Writes to RO registers ignored. Writes to A/B while busy ignored (operands frozen).
- Simultaneous host_wr and host_rd same cycle: both serviced; read returns pre-write value.
- FSM: IDLE -> (start=1 written) LOAD -> ADD -> WRITE -> IDLE.
  - LOAD: latch A,B into internal operands; busy=1; clear done; CYCLES=0.
  - ADD: stay exactly LAT cycles (internal countdown LAT-1..0); CYCLES increments each cycle in LOAD/ADD/WRITE.
  - WRITE: Y = (A+B) mod 2^WIDTH; carry = bit WIDTH of full sum; done=1 same edge; busy=0 on exit.
- Start-to-done latency: start write at cycle N -> done/Y visible in STATUS read issued at N+LAT+3 or later; CYCLES final = LAT+2.
- start written while busy: ignored (no restart, no queueing).
- start written same cycle as W1C of done while IDLE: start wins; done cleared by LOAD anyway.
- W1C of done in the same cycle WRITE sets it: set wins.
- irq follows done & irq_en combinationally from registers; deasserts cycle after done cleared or irq_en cleared.
- Y and carry hold until next WRITE; CYCLES holds after completion.

Test Plan:
- Reset then read each addr 0..7 -> 0,0,0,0,0,0,32'h5CA1_0ADD,0; host_rvalid exactly one cycle after each host_rd.
- Write A=3,B=4, start -> STATUS busy=1 during run; after LAT+3 cycles Y=7, STATUS=0b010, CYCLES=4 (LAT=2).
- A=32'hFFFF_FFFF, B=2, start -> Y=1, carry=1; then A=1,B=1, start -> Y=2, carry=0.
- During busy: write A=100, issue start again -> ignored; result uses original operands, single done, CYCLES=4.
- irq_en=1, run add -> irq rises with done; write STATUS=0b010 -> irq low next cycle; W1C coinciding with WRITE edge -> done stays 1.
- Assert reset mid-ADD -> all registers 0, FSM IDLE, done=0; subsequent start with A=5,B=6 -> Y=11.

Source files
------------

// File: rtl/scalar_add_ctrl_if.sv
// Host register bus for scalar_add_ctrl: single-cycle write/read strobes,
// a registered read return with its valid pulse, and the level interrupt.
interface scalar_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             host_wr;
  logic             host_rd;
  logic [2:0]       host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;
  logic             host_rvalid;
  logic             irq;

  modport master (
    output host_wr, host_rd, host_addr, host_wdata,
    input  host_rdata, host_rvalid, irq
  );

  modport slave (
    input  host_wr, host_rd, host_addr, host_wdata,
    output host_rdata, host_rvalid, irq
  );
endinterface

// File: rtl/scalar_add_ctrl.sv
// Register-mapped scalar adder: host writes A/B and a start bit, a small FSM
// runs the add over LAT cycles, and the host polls STATUS/Y/CYCLES.
module scalar_add_ctrl #(
  parameter int               WIDTH    = 32,
  parameter int               LAT      = 2,
  parameter logic [WIDTH-1:0] ID_VALUE = WIDTH'(32'h5CA1_0ADD)
) (
  input logic              clock,
  input logic              reset,
  scalar_add_ctrl_if.slave host
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_en_q, irq_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   cycles_q, cycles_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic [WIDTH-1:0]   rd_mux;
  logic [WIDTH:0]     sum;
  logic               wr_ctrl, wr_status, wr_a, wr_b, idle;

  assign sum       = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign idle      = (state_q == S_IDLE);
  assign wr_ctrl   = host.host_wr && (host.host_addr == 3'd0);
  assign wr_status = host.host_wr && (host.host_addr == 3'd1);
  assign wr_a      = host.host_wr && (host.host_addr == 3'd2);
  assign wr_b      = host.host_wr && (host.host_addr == 3'd3);

  // Read mux sees only current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (host.host_addr)
      3'd0:    rd_mux = {{(WIDTH-2){1'b0}}, irq_en_q, 1'b0};
      3'd1:    rd_mux = {{(WIDTH-3){1'b0}}, carry_q, done_q, busy_q};
      3'd2:    rd_mux = a_q;
      3'd3:    rd_mux = b_q;
      3'd4:    rd_mux = y_q;
      3'd5:    rd_mux = cycles_q;
      3'd6:    rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    y_d      = y_q;
    cycles_d = cycles_q;
    rdata_d  = rdata_q;
    rvalid_d = host.host_rd;

    if (host.host_rd) rdata_d = rd_mux;

    if (wr_ctrl)                        irq_en_d = host.host_wdata[1];
    if (wr_status && host.host_wdata[1]) done_d  = 1'b0;
    if (wr_a && idle)                   a_d      = host.host_wdata;
    if (wr_b && idle)                   b_d      = host.host_wdata;

    // FSM assignments come after the host writes so LOAD/WRITE override a W1C.
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && host.host_wdata[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        op_a_d   = a_q;
        op_b_d   = b_q;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        cycles_d = WIDTH'(1);
        cnt_d    = CNT_W'(LAT - 1);
        state_d  = S_ADD;
      end
      S_ADD: begin
        cycles_d = cycles_q + WIDTH'(1);
        if (cnt_q == '0) state_d = S_WRITE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WRITE: begin
        y_d      = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        cycles_d = cycles_q + WIDTH'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      y_q      <= '0;
      cycles_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      y_q      <= y_d;
      cycles_q <= cycles_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;
  assign host.irq         = done_q & irq_en_q;

endmodule
